// File: rtl/sram_line_writer.sv
// Buffers 128-bit packed lines in a small FIFO and writes each one to a 32-bit SRAM
// as four word beats, with optional WE_n-high hold cycles after every beat.
module sram_line_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT       = 0
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         enable,
  input  logic         line_vld,
  input  logic [18:0]  line_addr,
  input  logic [127:0] line_data,
  output logic [20:0]  SRAM_ADDR,
  output logic [31:0]  SRAM_DQ_OUT,
  output logic         SRAM_CE_n,
  output logic         SRAM_WE_n,
  output logic         busy,
  output logic         overflow,
  output logic [18:0]  lines_written
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [2:0]    WAIT_C  = 3'(WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic [127:0]  line_q, line_d;
  logic [18:0]   laddr_q, laddr_d;
  logic [20:0]   sram_addr_q, sram_addr_d;
  logic [31:0]   sram_dq_q, sram_dq_d;
  logic          ce_n_q, ce_n_d;
  logic          we_n_q, we_n_d;
  logic          overflow_q, overflow_d;
  logic [18:0]   lines_q, lines_d;

  logic [146:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          issue;
  logic          end_beat;
  logic [146:0]  head;

  function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] beat);
    logic [31:0] w;
    case (beat)
      2'd0:    w = line[127:96];
      2'd1:    w = line[95:64];
      2'd2:    w = line[63:32];
      default: w = line[31:0];
    endcase
    return w;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign head       = mem_q[rd_ptr_q];

  // Outputs are registered, so each transition computes the pin values of the state it enters.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wcnt_d      = wcnt_q;
    line_d      = line_q;
    laddr_d     = laddr_q;
    sram_addr_d = sram_addr_q;
    sram_dq_d   = sram_dq_q;
    ce_n_d      = 1'b1;
    we_n_d      = 1'b1;
    lines_d     = lines_q;
    pop         = 1'b0;
    issue       = 1'b0;
    end_beat    = ((state_q == BEAT) && (WAIT == 0)) ||
                  ((state_q == HOLD) && (wcnt_q == 3'd1));

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      BEAT: begin
        if (!end_beat) begin
          state_d = HOLD;
          wcnt_d  = WAIT_C;
          ce_n_d  = 1'b0;
        end
      end
      HOLD: begin
        if (!end_beat) begin
          wcnt_d = wcnt_q - 3'd1;
          ce_n_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (end_beat) begin
      if (beat_q != 2'd3) begin
        beat_d = beat_q + 2'd1;
        issue  = 1'b1;
      end else begin
        lines_d = lines_q + 19'd1;
        if (!fifo_empty) begin
          pop = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    end

    if (pop) begin
      line_d  = head[127:0];
      laddr_d = head[146:128];
      beat_d  = 2'd0;
      issue   = 1'b1;
    end

    if (issue) begin
      state_d     = BEAT;
      ce_n_d      = 1'b0;
      we_n_d      = 1'b0;
      sram_addr_d = {laddr_d, beat_d};
      sram_dq_d   = word_sel(line_d, beat_d);
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  always_comb begin
    push       = line_vld && (!fifo_full || pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q || (line_vld && fifo_full && !pop);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn || !enable) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      wcnt_q      <= 3'd0;
      line_q      <= '0;
      laddr_q     <= '0;
      sram_addr_q <= '0;
      sram_dq_q   <= '0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      overflow_q  <= 1'b0;
      lines_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wcnt_q      <= wcnt_d;
      line_q      <= line_d;
      laddr_q     <= laddr_d;
      sram_addr_q <= sram_addr_d;
      sram_dq_q   <= sram_dq_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      overflow_q  <= overflow_d;
      lines_q     <= lines_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {line_addr, line_data};
    end
  end

  assign SRAM_ADDR     = sram_addr_q;
  assign SRAM_DQ_OUT   = sram_dq_q;
  assign SRAM_CE_n     = ce_n_q;
  assign SRAM_WE_n     = we_n_q;
  assign overflow      = overflow_q;
  assign lines_written = lines_q;
  assign busy          = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_sram_line_writer.sv
// Drives three writers (WAIT = 0, 1, 3) from shared stimulus and checks each one every
// cycle against a timeline model of the line writes, plus hand-computed expectations.
module tb_sram_line_writer;

  localparam int NI    = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         enable;
  logic         line_vld;
  logic [18:0]  line_addr;
  logic [127:0] line_data;

  logic [20:0]  o_addr  [NI];
  logic [31:0]  o_dq    [NI];
  logic         o_ce_n  [NI];
  logic         o_we_n  [NI];
  logic         o_busy  [NI];
  logic         o_ovf   [NI];
  logic [18:0]  o_lines [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_line_writer #(
      .FIFO_DEPTH(DEPTH),
      .WAIT      ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .CLK          (clk),
      .RSTn         (rst_n),
      .enable       (enable),
      .line_vld     (line_vld),
      .line_addr    (line_addr),
      .line_data    (line_data),
      .SRAM_ADDR    (o_addr[g]),
      .SRAM_DQ_OUT  (o_dq[g]),
      .SRAM_CE_n    (o_ce_n[g]),
      .SRAM_WE_n    (o_we_n[g]),
      .busy         (o_busy[g]),
      .overflow     (o_ovf[g]),
      .lines_written(o_lines[g])
    );
  end

  int checks = 0;
  int passes = 0;

  function automatic int waitOf(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: a line occupies 4*(1+W) cycles after it is taken from the queue; within it the
  // cycle offset alone gives the beat (offset / (1+W)) and whether WE_n is low (remainder 0).
  logic [146:0] mf     [NI][DEPTH];
  int           mhead  [NI];
  int           mcnt   [NI];
  int           moff   [NI];
  logic [146:0] mline  [NI];
  bit           mact   [NI];
  logic [18:0]  mlines [NI];
  bit           movf   [NI];
  logic [20:0]  eaddr  [NI];
  logic [31:0]  edq    [NI];
  logic         ece    [NI];
  logic         ewe    [NI];
  logic         ebusy  [NI];
  bit           model_ok = 1'b0;
  int           mw, mph, mbt;

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      mw = waitOf(k);
      if (!rst_n || !enable) begin
        mhead[k]  = 0;
        mcnt[k]   = 0;
        moff[k]   = 0;
        mact[k]   = 1'b0;
        mlines[k] = '0;
        movf[k]   = 1'b0;
        eaddr[k]  = '0;
        edq[k]    = '0;
        ece[k]    = 1'b1;
        ewe[k]    = 1'b1;
      end else begin
        if (mact[k]) begin
          moff[k]++;
          if (moff[k] == 4 * (1 + mw)) begin
            mlines[k] = mlines[k] + 19'd1;
            mact[k]   = 1'b0;
          end
        end
        if (!mact[k] && mcnt[k] > 0) begin
          mline[k] = mf[k][mhead[k]];
          mhead[k] = (mhead[k] + 1) % DEPTH;
          mcnt[k]--;
          mact[k]  = 1'b1;
          moff[k]  = 0;
        end
        if (line_vld) begin
          if (mcnt[k] < DEPTH) begin
            mf[k][(mhead[k] + mcnt[k]) % DEPTH] = {line_addr, line_data};
            mcnt[k]++;
          end else begin
            movf[k] = 1'b1;
          end
        end
        if (mact[k]) begin
          mph    = moff[k] % (1 + mw);
          mbt    = moff[k] / (1 + mw);
          ece[k] = 1'b0;
          ewe[k] = (mph != 0);
          if (mph == 0) begin
            eaddr[k] = {mline[k][146:128], 2'(mbt)};
            edq[k]   = mline[k][127 - 32 * mbt -: 32];
          end
        end else begin
          ece[k] = 1'b1;
          ewe[k] = 1'b1;
        end
      end
      ebusy[k] = mact[k] || (mcnt[k] > 0);
    end
    if (!rst_n) begin
      model_ok = 1'b1;
    end
  end

  // Every cycle, every instance, every output against the model.
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      for (int k = 0; k < NI; k++) begin
        checkOutput($sformatf("w%0d SRAM_ADDR", k), 128'(o_addr[k]), 128'(eaddr[k]));
        checkOutput($sformatf("w%0d SRAM_DQ_OUT", k), 128'(o_dq[k]), 128'(edq[k]));
        checkOutput($sformatf("w%0d SRAM_CE_n", k), 128'(o_ce_n[k]), 128'(ece[k]));
        checkOutput($sformatf("w%0d SRAM_WE_n", k), 128'(o_we_n[k]), 128'(ewe[k]));
        checkOutput($sformatf("w%0d busy", k), 128'(o_busy[k]), 128'(ebusy[k]));
        checkOutput($sformatf("w%0d overflow", k), 128'(o_ovf[k]), 128'(movf[k]));
        checkOutput($sformatf("w%0d lines_written", k), 128'(o_lines[k]), 128'(mlines[k]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    enable   = 1'b1;
    line_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [18:0] a, input logic [127:0] d);
    line_vld  = 1'b1;
    line_addr = a;
    line_data = d;
    @(negedge clk);
    line_vld  = 1'b0;
    line_addr = '0;
    line_data = '0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while ((o_busy[0] || o_busy[1] || o_busy[2]) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain within cycle bound", 128'(n < limit), 128'(1));
  endtask

  logic [31:0] t1_words [4];

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    line_vld  = 1'b0;
    line_addr = '0;
    line_data = '0;
    t1_words  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    // Single line, latency and beat order on the WAIT=0 writer.
    doReset();
    checkOutput("reset CE_n", 128'(o_ce_n[0]), 128'(1));
    checkOutput("reset WE_n", 128'(o_we_n[0]), 128'(1));
    checkOutput("reset lines_written", 128'(o_lines[0]), 128'(0));
    applyStimulus(19'h00005, 128'h11111111_22222222_33333333_44444444);
    tick(1);
    for (int b = 0; b < 4; b++) begin
      checkOutput($sformatf("single WE_n beat%0d", b), 128'(o_we_n[0]), 128'(0));
      checkOutput($sformatf("single ADDR beat%0d", b), 128'(o_addr[0]), 128'(21'h14 + 21'(b)));
      checkOutput($sformatf("single DQ beat%0d", b), 128'(o_dq[0]), 128'(t1_words[b]));
      tick(1);
    end
    checkOutput("single lines_written", 128'(o_lines[0]), 128'(1));
    checkOutput("single busy", 128'(o_busy[0]), 128'(0));
    waitIdle(400);

    // Stream of 8 lines at one per 4 cycles: 32 back-to-back WE_n-low beats.
    doReset();
    for (int c = 0; c < 34; c++) begin
      if (c % 4 == 0 && c < 32) begin
        line_vld  = 1'b1;
        line_addr = 19'(c / 4);
        line_data = {32'(c + 100), 32'(c + 200), 32'(c + 300), 32'(c + 400)};
      end else begin
        line_vld = 1'b0;
      end
      if (c >= 2) begin
        checkOutput($sformatf("stream WE_n c%0d", c), 128'(o_we_n[0]), 128'(0));
        checkOutput($sformatf("stream ADDR c%0d", c), 128'(o_addr[0]), 128'(c - 2));
      end
      tick(1);
    end
    line_vld = 1'b0;
    waitIdle(400);
    checkOutput("stream lines_written", 128'(o_lines[0]), 128'(8));
    checkOutput("stream overflow", 128'(o_ovf[0]), 128'(0));

    // Back-pressure: 16 lines at one per 4 cycles into the WAIT=1 writer drops 4 of them.
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(19'h100 + 19'(i), {4{32'(i * 3 + 5)}} ^ 128'h0F0F_0000_F0F0_0000_1234_0000_4321_0000);
      if (i == 0) begin
        tick(1);
        checkOutput("bp beat WE_n", 128'(o_we_n[1]), 128'(0));
        checkOutput("bp beat CE_n", 128'(o_ce_n[1]), 128'(0));
        checkOutput("bp beat ADDR", 128'(o_addr[1]), 128'(21'h400));
        tick(1);
        checkOutput("bp hold WE_n", 128'(o_we_n[1]), 128'(1));
        checkOutput("bp hold CE_n", 128'(o_ce_n[1]), 128'(0));
        checkOutput("bp hold ADDR", 128'(o_addr[1]), 128'(21'h400));
        tick(1);
      end else begin
        tick(3);
      end
    end
    waitIdle(400);
    checkOutput("bp overflow w1", 128'(o_ovf[1]), 128'(1));
    checkOutput("bp lines_written w1", 128'(o_lines[1]), 128'(12));
    checkOutput("bp overflow w0", 128'(o_ovf[0]), 128'(0));
    checkOutput("bp lines_written w0", 128'(o_lines[0]), 128'(16));

    // Fill the WAIT=3 FIFO, then push exactly on the edge that pops the next line.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(19'h200 + 19'(i), {4{32'hC0DE0000 + 32'(i)}});
    end
    tick(12);
    checkOutput("full last hold WE_n", 128'(o_we_n[2]), 128'(1));
    checkOutput("full last hold ADDR", 128'(o_addr[2]), 128'(21'h803));
    applyStimulus(19'h2FF, 128'hDEAD0001_DEAD0002_DEAD0003_DEAD0004);
    checkOutput("full+pop overflow", 128'(o_ovf[2]), 128'(0));
    checkOutput("full+pop next ADDR", 128'(o_addr[2]), 128'(21'h804));
    checkOutput("full+pop next WE_n", 128'(o_we_n[2]), 128'(0));
    waitIdle(400);
    checkOutput("full+pop lines_written", 128'(o_lines[2]), 128'(6));
    checkOutput("full+pop overflow end", 128'(o_ovf[2]), 128'(0));

    // Abort with enable low during beat 2, then restart.
    doReset();
    applyStimulus(19'h00010, 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004);
    tick(3);
    checkOutput("abort beat2 ADDR", 128'(o_addr[0]), 128'(21'h42));
    checkOutput("abort beat2 WE_n", 128'(o_we_n[0]), 128'(0));
    enable = 1'b0;
    tick(1);
    checkOutput("abort CE_n", 128'(o_ce_n[0]), 128'(1));
    checkOutput("abort WE_n", 128'(o_we_n[0]), 128'(1));
    checkOutput("abort lines_written", 128'(o_lines[0]), 128'(0));
    checkOutput("abort busy", 128'(o_busy[0]), 128'(0));
    enable = 1'b1;
    applyStimulus(19'h00020, 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004);
    tick(1);
    checkOutput("restart ADDR", 128'(o_addr[0]), 128'(21'h80));
    checkOutput("restart WE_n", 128'(o_we_n[0]), 128'(0));
    checkOutput("restart DQ", 128'(o_dq[0]), 128'(32'hBBBB0001));
    waitIdle(400);

    // Reset pulse while the WAIT=1 writer is in a hold cycle with a line still queued.
    doReset();
    applyStimulus(19'h00033, 128'h33330001_33330002_33330003_33330004);
    applyStimulus(19'h00034, 128'h34340001_34340002_34340003_34340004);
    tick(1);
    checkOutput("rst hold WE_n", 128'(o_we_n[1]), 128'(1));
    checkOutput("rst hold CE_n", 128'(o_ce_n[1]), 128'(0));
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    checkOutput("rst ADDR", 128'(o_addr[1]), 128'(0));
    checkOutput("rst DQ", 128'(o_dq[1]), 128'(0));
    checkOutput("rst CE_n", 128'(o_ce_n[1]), 128'(1));
    checkOutput("rst WE_n", 128'(o_we_n[1]), 128'(1));
    checkOutput("rst overflow", 128'(o_ovf[1]), 128'(0));
    checkOutput("rst lines_written", 128'(o_lines[1]), 128'(0));
    checkOutput("rst busy", 128'(o_busy[1]), 128'(0));
    tick(3);
    checkOutput("rst fifo empty busy", 128'(o_busy[1]), 128'(0));
    checkOutput("rst fifo empty CE_n", 128'(o_ce_n[1]), 128'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_line_writer.md
# sram_line_writer

Write back-end of the SRAM init path. It takes 128-bit packed lines with 19-bit line addresses from the word-packing stage and buffers them in a small FIFO. Each line is then written to a 32-bit-wide external SRAM as four consecutive word beats. The block generates CE_n/WE_n and word addresses, and reports progress and overflow to the loader control.

## Interface
Parameters:
- FIFO_DEPTH, 4, line FIFO entries; power of two, ≥2
- WAIT, 0, extra hold cycles per beat; WE_n is high during these cycles (0..7)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RSTn  in  1  reset, synchronous, active-low
- enable  in  1  stream enable; low = flush/abort, same effect as reset
- line_vld  in  1  one-cycle strobe; line_addr/line_data are valid this cycle
- line_addr  in  19  line address from packing stage
- line_data  in  128  packed line; [127:96] is the first word received
- SRAM_ADDR  out  21  word address = {line_addr, beat[1:0]}
- SRAM_DQ_OUT  out  32  write data
- SRAM_CE_n  out  1  chip enable, active-low
- SRAM_WE_n  out  1  write enable, active-low
- busy  out  1  FIFO non-empty or FSM not IDLE (combinational from registered state)
- overflow  out  1  sticky; a line_vld was dropped because the FIFO was full
- lines_written  out  19  count of fully written lines, wraps at 2^19

## Operation
- Reset (RSTn=0 at an edge) or enable=0 at an edge produces the same result:
  - Outputs: SRAM_ADDR=0, SRAM_DQ_OUT=0, SRAM_CE_n=1, SRAM_WE_n=1, overflow=0, lines_written=0.
  - FIFO is emptied and FSM goes to IDLE.
  - Any line in progress is abandoned mid-beat with no completion.
- Push: line_vld & enable & (not full, or a pop in the same cycle) stores {line_addr, line_data}.
  - line_vld while full with no pop: line dropped, FIFO unchanged, overflow set to 1.
  - overflow stays 1 until reset or enable=0.
- FSM states: IDLE, BEAT, HOLD.
- IDLE:
  - If the FIFO is non-empty: pop, load line/addr registers, beat=0, go to BEAT.
  - Otherwise hold CE_n=1 and WE_n=1. SRAM_ADDR and SRAM_DQ_OUT keep their last values.
- BEAT (one cycle):
  - CE_n=0, WE_n=0.
  - SRAM_ADDR={addr, beat}.
  - SRAM_DQ_OUT = word[beat], where word0=[127:96], word1=[95:64], word2=[63:32], word3=[31:0].
  - If WAIT>0, go to HOLD with wcnt=WAIT.
- HOLD:
  - CE_n=0, WE_n=1; ADDR/DQ held unchanged; wcnt decrements.
  - Beat ends when wcnt reaches 1 (or immediately after BEAT when WAIT=0).
- End of beat with beat<3: beat+1, go to BEAT.
- End of beat 3:
  - lines_written+1.
  - If the FIFO is non-empty: pop and start beat 0 of the next line in the following cycle (no idle bubble).
  - Otherwise go to IDLE.
- FIFO: pop-before-push when both occur in the same cycle. Count stays within 0..FIFO_DEPTH.
- Address arithmetic: 19-bit line address concatenated with 2-bit beat index; no carry into the line field.

## Timing
- All outputs are registered except busy.
- Latency: line_vld in cycle 0 into an empty, idle block gives WE_n=0 for beat 0 in cycle 2.
- Beat k of a line starts (1+WAIT)·k cycles after beat 0.
- Line duration is 4·(1+WAIT) cycles.
  - WAIT=0: 4 cycles per line, which matches the upstream rate of one line per 4 cycles with no FIFO growth.
  - WAIT>0: the FIFO absorbs the rate mismatch until full, then overflow sets.
- lines_written updates on the edge that ends beat 3; the new value is visible in the next cycle.
- enable falling mid-line: at the next edge CE_n and WE_n go to 1. No further beats are issued, and lines_written is cleared.

## Test plan
- Single line: WAIT=0, line_addr=0x00005, line_data=0x11111111_22222222_33333333_44444444.
  - Expected: cycles 2..5 show WE_n=0 with ADDR 0x14,0x15,0x16,0x17 and DQ 0x11111111,0x22222222,0x33333333,0x44444444.
  - lines_written=1 in cycle 6; busy=0 from cycle 6.
- Stream: WAIT=0, line_vld every 4 cycles for 8 lines, addrs 0..7.
  - Expected: WE_n low for 32 consecutive cycles with SRAM_ADDR 0..31 sequential, overflow=0, lines_written=8.
- Back-pressure: WAIT=1, FIFO_DEPTH=4, line_vld every 4 cycles for 16 lines.
  - Expected: each beat is WE_n low for 1 cycle then high for 1 cycle, overflow=1, no FIFO count above 4.
  - After drain, lines_written equals the number of accepted pushes; every written ADDR belongs to an accepted line.
- Full with simultaneous pop: fill the FIFO with WAIT=3, then assert line_vld in the cycle of a pop.
  - Expected: line accepted, overflow stays 0.
- Abort: drop enable during beat 2 of line 0x00010.
  - Expected: next cycle CE_n=1, WE_n=1, lines_written=0, busy=0.
  - With enable high again, a new line writes from beat 0.
- Reset mid-stream: RSTn=0 for 1 cycle during HOLD.
  - Expected: all outputs at reset values in the following cycle and the FIFO empty.
